// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU requester port, DMA requester port and the
// single-ported memory side. The arbiter uses the slave view, its environment the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic          dma_err;
    logic [DW-1:0] dma_rdata;

    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_err, dma_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_err, dma_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a DMA engine.
// One access is in flight at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        ID_CPU = 1'b0,
        ID_DMA = 1'b1
    } id_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    id_t           last_grant;
    id_t           id_q;
    id_t           winner;
    logic          grant;
    logic          cpu_elig;
    logic          dma_elig;

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic [3:0]    cnt;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic          misaligned;
    logic          cpu_ack;
    logic          dma_ack;

    assign misaligned = (addr_q[1:0] != 2'b00);

    // The port being acked in RESP is masked so the other side gets the next slot.
    always_comb begin
        // NOTE: every signal of this block gets a default first, so no latch is inferred.
        cpu_elig = bus.cpu_req && !(state == RESP && id_q == ID_CPU);
        dma_elig = bus.dma_req && !(state == RESP && id_q == ID_DMA);
        grant    = (state == IDLE || state == RESP) && (cpu_elig || dma_elig);
        winner   = ID_CPU;
        if (cpu_elig && dma_elig) begin
            winner = (last_grant == ID_CPU) ? ID_DMA : ID_CPU;
        end else if (dma_elig) begin
            winner = ID_DMA;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? ISSUE : IDLE;
            ISSUE:   state_nxt = misaligned ? RESP : WAIT;
            WAIT:    state_nxt = (cnt == 4'd0) ? RESP : WAIT;
            RESP:    state_nxt = grant ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= ID_DMA;
            id_q       <= ID_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant) begin
            last_grant <= winner;
            id_q       <= winner;
            if (winner == ID_CPU) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end else begin
                we_q    <= bus.dma_we;
                addr_q  <= bus.dma_addr;
                wdata_q <= bus.dma_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            if (state == ISSUE) begin
                err_q <= misaligned;
                cnt   <= LAT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // NOTE: read-data registers are few and visible at the ports, so they sit on the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (state == WAIT && cnt == 4'd0 && !we_q) begin
            if (id_q == ID_CPU) begin
                cpu_rdata_q <= bus.mem_rdata;
            end else begin
                dma_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Strobes and acks decode the state register, so an async reset clears them at once.
    assign bus.mem_rd    = (state == ISSUE) && !misaligned && !we_q;
    assign bus.mem_wr    = (state == ISSUE) && !misaligned && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign cpu_ack       = (state == RESP) && (id_q == ID_CPU);
    assign dma_ack       = (state == RESP) && (id_q == ID_DMA);
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_err   = cpu_ack && err_q;
    assign bus.dma_err   = dma_ack && err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single accesses on a MEM_LAT=1
// instance plus hand-written sequences for ties, back-to-back grants, MEM_LAT=4 and reset.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus4 ();

    mem_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_arbiter #(.MEM_LAT(4), .AW(AW), .DW(DW)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_ack;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] outs1();
        return 160'({bus1.cpu_ack, bus1.dma_ack, bus1.cpu_err, bus1.dma_err, bus1.mem_rd,
                     bus1.mem_wr, bus1.cpu_stall, bus1.mem_addr, bus1.mem_wdata,
                     bus1.cpu_rdata, bus1.dma_rdata});
    endfunction

    function automatic logic [159:0] outs4();
        return 160'({bus4.cpu_ack, bus4.dma_ack, bus4.cpu_err, bus4.dma_err, bus4.mem_rd,
                     bus4.mem_wr, bus4.cpu_stall, bus4.mem_addr, bus4.mem_wdata,
                     bus4.cpu_rdata, bus4.dma_rdata});
    endfunction

    // One isolated access on the MEM_LAT=1 instance; k counts negedges after the grant edge.
    task automatic run_vec(input int idx, input vec_t v);
        int          ack_k    = 0;
        int          strobe_k = 0;
        int          n_strobe = 0;
        logic        got_rd   = 1'b0;
        logic        got_wr   = 1'b0;
        logic [31:0] s_addr   = '0;
        logic [31:0] s_wdata  = '0;
        logic        got_err  = 1'b0;
        logic [31:0] got_rd_v = '0;
        logic        oth_seen = 1'b0;
        logic        stall_ok = 1'b1;
        logic        my_ack;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.is_dma) begin
            bus1.dma_req = 1'b1; bus1.dma_we = v.we; bus1.dma_addr = v.addr; bus1.dma_wdata = v.wdata;
        end else begin
            bus1.cpu_req = 1'b1; bus1.cpu_we = v.we; bus1.cpu_addr = v.addr; bus1.cpu_wdata = v.wdata;
        end
        bus1.mem_rdata = v.mdata;
        for (int k = 1; k <= 12 && ack_k == 0; k++) begin
            @(negedge clk);
            if (bus1.mem_rd || bus1.mem_wr) begin
                n_strobe++;
                strobe_k = k;
                got_rd   = bus1.mem_rd;
                got_wr   = bus1.mem_wr;
                s_addr   = bus1.mem_addr;
                s_wdata  = bus1.mem_wdata;
            end
            my_ack = v.is_dma ? bus1.dma_ack : bus1.cpu_ack;
            if (v.is_dma ? bus1.cpu_ack : bus1.dma_ack) oth_seen = 1'b1;
            if (bus1.cpu_stall !== (!v.is_dma && !my_ack)) stall_ok = 1'b0;
            if (my_ack) begin
                ack_k    = k;
                got_err  = v.is_dma ? bus1.dma_err : bus1.cpu_err;
                got_rd_v = v.is_dma ? bus1.dma_rdata : bus1.cpu_rdata;
            end
        end
        @(posedge clk);
        #1;
        bus1.cpu_req = 1'b0;
        bus1.dma_req = 1'b0;

        check({tag, " ack_cycle"}, 160'(ack_k), 160'(v.exp_ack));
        check({tag, " err"}, 160'(got_err), 160'(v.exp_err));
        check({tag, " rdata"}, 160'(got_rd_v), 160'(v.exp_rdata));
        check({tag, " other_ack"}, 160'(oth_seen), 160'(0));
        check({tag, " stall"}, 160'(stall_ok), 160'(1));
        if (v.exp_err) begin
            check({tag, " strobes"}, 160'(n_strobe), 160'(0));
        end else begin
            check({tag, " strobes"}, 160'(n_strobe), 160'(1));
            check({tag, " strobe_cycle"}, 160'(strobe_k), 160'(1));
            check({tag, " strobe_kind"}, 160'({got_rd, got_wr}), 160'({!v.we, v.we}));
            check({tag, " mem_addr"}, 160'(s_addr), 160'(v.addr));
            if (v.we) check({tag, " mem_wdata"}, 160'(s_wdata), 160'(v.wdata));
        end
    endtask

    initial begin
        int          order[4];
        int          ack_at[4];
        int          str_at[4];
        int          n_ack;
        int          n_str;
        int          ack_k;
        int          strobe_k;
        int          n_strobe;
        logic [31:0] rd_v;
        logic        bad_ack;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0102, 32'h0000_0055, 32'h2222_2222, 1'b1, 32'hCAFE_F00D, 2};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0101_0101, 1'b1, 32'hDEAD_BEEF, 2};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b0, 32'h0000_0000, 3};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 3};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h3333_3333, 1'b0, 32'h0000_0000, 3};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_0042, 1'b1, 32'hA5A5_A5A5, 2};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 3};

        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = '0; bus1.dma_wdata = '0;
        bus1.mem_rdata = '0;
        bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
        bus4.dma_req = 0; bus4.dma_we = 0; bus4.dma_addr = '0; bus4.dma_wdata = '0;
        bus4.mem_rdata = '0;

        #1;
        check("reset_outs_lat1", outs1(), 160'(0));
        check("reset_outs_lat4", outs4(), 160'(0));

        // Both requests high from the first cycle after reset: CPU wins the first tie.
        bus1.cpu_req = 1'b1; bus1.cpu_addr = 32'h40;
        bus1.dma_req = 1'b1; bus1.dma_addr = 32'h80;
        bus1.mem_rdata = 32'h1111_1111;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin order[i] = -1; ack_at[i] = -1; str_at[i] = -1; end
        n_ack = 0;
        n_str = 0;
        for (int k = 1; k <= 16 && n_ack < 4; k++) begin
            @(negedge clk);
            if (bus1.mem_rd && n_str < 4) begin str_at[n_str] = k; n_str++; end
            if (bus1.cpu_ack) begin order[n_ack] = 0; ack_at[n_ack] = k; n_ack++; end
            else if (bus1.dma_ack) begin order[n_ack] = 1; ack_at[n_ack] = k; n_ack++; end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie_order%0d", i), 160'(order[i]), 160'(i % 2));
            check($sformatf("tie_ack_cycle%0d", i), 160'(ack_at[i]), 160'(3 + 3 * i));
            check($sformatf("tie_strobe_cycle%0d", i), 160'(str_at[i]), 160'(1 + 3 * i));
        end

        reset = 1'b0;
        bus1.cpu_req = 1'b0;
        bus1.dma_req = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_clears_tie", outs1(), 160'(0));
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Misaligned DMA write; a CPU request raised meanwhile is granted in the same RESP.
        @(negedge clk);
        bus1.dma_req = 1'b1; bus1.dma_we = 1'b1; bus1.dma_addr = 32'h102; bus1.dma_wdata = 32'h55;
        @(negedge clk);
        check("mis_issue_strobes", 160'({bus1.mem_rd, bus1.mem_wr}), 160'(0));
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h30;
        bus1.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("mis_resp", 160'({bus1.dma_ack, bus1.dma_err, bus1.cpu_ack, bus1.mem_wr}), 160'(4'b1100));
        @(posedge clk);
        #1;
        bus1.dma_req = 1'b0;
        @(negedge clk);
        check("resp_grant_strobe", 160'({bus1.mem_rd, bus1.mem_addr}), 160'({1'b1, 32'h30}));
        repeat (2) @(negedge clk);
        check("resp_grant_ack", 160'({bus1.cpu_ack, bus1.cpu_err, bus1.cpu_rdata}),
              160'({1'b1, 1'b0, 32'h7777_7777}));
        @(posedge clk);
        #1;
        bus1.cpu_req = 1'b0;

        // MEM_LAT=4: read data sampled 4 cycles after the strobe, ack at grant+6.
        @(negedge clk);
        bus4.dma_req = 1'b1; bus4.dma_we = 1'b0; bus4.dma_addr = 32'h200;
        bus4.mem_rdata = 32'h1000_0000;
        ack_k = 0; strobe_k = 0; n_strobe = 0; rd_v = '0; bad_ack = 1'b0;
        for (int k = 1; k <= 12 && ack_k == 0; k++) begin
            @(negedge clk);
            if (bus4.mem_rd || bus4.mem_wr) begin n_strobe++; strobe_k = k; end
            if (bus4.cpu_ack) bad_ack = 1'b1;
            if (bus4.dma_ack) begin ack_k = k; rd_v = bus4.dma_rdata; end
            bus4.mem_rdata = 32'h1000_0000 + 32'(k);
        end
        @(posedge clk);
        #1;
        bus4.dma_req = 1'b0;
        check("lat4_strobes", 160'(n_strobe), 160'(1));
        check("lat4_strobe_cycle", 160'(strobe_k), 160'(1));
        check("lat4_ack_cycle", 160'(ack_k), 160'(6));
        check("lat4_rdata", 160'(rd_v), 160'(32'h1000_0005));
        check("lat4_cpu_ack", 160'(bad_ack), 160'(0));

        // Reset during WAIT aborts the access; outputs clear without a clock edge.
        @(negedge clk);
        bus4.dma_req = 1'b1; bus4.dma_addr = 32'h300; bus4.mem_rdata = 32'h9999_9999;
        repeat (2) @(negedge clk);
        check("pre_reset_rdata", 160'(bus4.dma_rdata), 160'(32'h1000_0005));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_lat4", outs4(), 160'(0));
        check("async_reset_lat1", outs1(), 160'(0));
        bad_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus4.dma_ack || bus4.cpu_ack) bad_ack = 1'b1;
        end
        check("no_ack_in_reset", 160'(bad_ack), 160'(0));
        reset = 1'b1;
        @(negedge clk);
        check("grant_after_release", 160'({bus4.mem_rd, bus4.mem_addr}), 160'({1'b1, 32'h300}));
        ack_k = 0;
        for (int k = 2; k <= 12 && ack_k == 0; k++) begin
            @(negedge clk);
            if (bus4.dma_ack) ack_k = k;
        end
        check("post_reset_ack_cycle", 160'(ack_k), 160'(6));
        check("post_reset_rdata", 160'(bus4.dma_rdata), 160'(32'h9999_9999));
        @(posedge clk);
        #1;
        bus4.dma_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
